// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported on-chip SRAM.
// Port 0 is the CPU, port 1 a secondary master (DMA / loader).
//
// Handshake (both master ports): a master raises mN_valid with wstrb/addr/wdata
// stable and holds them until mN_ready. mN_ready is a single-cycle completion
// pulse; mN_rdata is meaningful only while mN_ready=1 and is 0 otherwise.
// The slave side pulses s_select for one cycle and expects s_ready one cycle
// later. If s_ready never arrives, the WAIT-state watchdog completes the access
// with 32'hDEADBEEF and raises the sticky err flag.
module sram_arbiter #(
   parameter int ADDRWIDTH = 13,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m0_valid,
   input  logic [3:0]           m0_wstrb,
   input  logic [ADDRWIDTH-1:0] m0_addr,
   input  logic [31:0]          m0_wdata,
   output logic                 m0_ready,
   output logic [31:0]          m0_rdata,
   input  logic                 m1_valid,
   input  logic [3:0]           m1_wstrb,
   input  logic [ADDRWIDTH-1:0] m1_addr,
   input  logic [31:0]          m1_wdata,
   output logic                 m1_ready,
   output logic [31:0]          m1_rdata,
   output logic                 s_select,
   output logic [3:0]           s_wstrb,
   output logic [ADDRWIDTH-1:0] s_addr,
   output logic [31:0]          s_wdata,
   input  logic                 s_ready,
   input  logic [31:0]          s_rdata,
   output logic                 err,
   output logic                 err_port
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t      state, state_nx;
   logic        grant, grant_nx;
   logic        last_grant;
   logic        take;
   logic [3:0]  cap_wstrb;
   logic [7:0]  wait_cnt;
   logic        timeout_hit;
   logic        done;
   logic [31:0] resp_data;

   // The watchdog fires on the TIMEOUT-th consecutive WAIT cycle without s_ready.
   assign timeout_hit = (state == WAIT) && !s_ready && (wait_cnt == 8'(TIMEOUT - 1));
   assign done        = (state == WAIT) && (s_ready || timeout_hit);
   assign resp_data   = s_ready ? s_rdata : 32'hDEADBEEF;

   // Next-state and grant selection; on a tie the port that did not win last time goes.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      take     = 1'b0;
      case (state)
         IDLE: begin
            if (m0_valid && m1_valid) begin
               grant_nx = ~last_grant;
               take     = 1'b1;
            end else if (m0_valid) begin
               grant_nx = 1'b0;
               take     = 1'b1;
            end else if (m1_valid) begin
               grant_nx = 1'b1;
               take     = 1'b1;
            end
            if (take) state_nx = ISSUE;
         end
         ISSUE:   state_nx = WAIT;
         WAIT:    if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Slave strobes are live only in ISSUE; completion is steered to the granted port.
   always_comb begin
      s_select = (state == ISSUE);
      s_wstrb  = (state == ISSUE) ? cap_wstrb : 4'b0000;
      m0_ready = done && !grant;
      m1_ready = done && grant;
      m0_rdata = (done && !grant) ? resp_data : 32'h0;
      m1_rdata = (done && grant)  ? resp_data : 32'h0;
   end

   // State, grant history and captured request fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         cap_wstrb  <= 4'b0000;
         s_addr     <= '0;
         s_wdata    <= 32'h0;
      end else begin
         state <= state_nx;
         if (take) begin
            grant      <= grant_nx;
            last_grant <= grant_nx;
            cap_wstrb  <= grant_nx ? m1_wstrb : m0_wstrb;
            s_addr     <= grant_nx ? m1_addr  : m0_addr;
            s_wdata    <= grant_nx ? m1_wdata : m0_wdata;
         end
      end
   end

   // Watchdog counter and sticky error reporting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 8'd0;
         err      <= 1'b0;
         err_port <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            wait_cnt <= 8'd0;
         end else if (state == WAIT && !s_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            err      <= 1'b1;
            err_port <= grant;
         end
      end
   end

endmodule
